uart_receiver: RTL and testbench



---
 rtl/uart_pkg.sv | 39 +++
 rtl/uart_receiver_if.sv | 26 ++
 rtl/baud_controller.sv | 37 +++
 rtl/uart_receiver.sv | 153 +++++++++++++++
 tb/tb_uart_receiver.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, receiver state enum and baud divisor helper
// Purpose: one place for frame constants and baud divisors so TX and RX rates agree.
// Contents: CLK_HZ_DEFAULT, DATA_BITS, OVERSAMPLE, rx_state_t, baud_rate(), baud_divisor().
package uart_pkg;

  localparam int CLK_HZ_DEFAULT = 50_000_000;
  localparam int DATA_BITS      = 8;
  localparam int OVERSAMPLE     = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // baud_select code to line rate in bits per second.
  function automatic int baud_rate(logic [2:0] sel);
    case (sel)
      3'd0:    return 300;
      3'd1:    return 1200;
      3'd2:    return 4800;
      3'd3:    return 9600;
      3'd4:    return 19200;
      3'd5:    return 38400;
      3'd6:    return 57600;
      default: return 115200;
    endcase
  endfunction

  // Clock cycles per sample tick, rounded to nearest: round(clk / (16 * baud)).
  function automatic logic [15:0] baud_divisor(int clk_hz, logic [2:0] sel);
    int r;
    r = baud_rate(sel);
    return 16'((clk_hz + 8 * r) / (16 * r));
  endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// rtl/uart_receiver_if.sv - host-side signal bundle of the UART receiver
// Purpose: groups configuration, serial input and received-frame reporting.
// slave  (receiver): in baud_select, Rx_EN, RxD; out Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_BUSY.
// master (host)    : the mirror image.
interface uart_receiver_if
  import uart_pkg::*;
;
  logic [2:0]           baud_select;
  logic                 Rx_EN;
  logic                 RxD;
  logic [DATA_BITS-1:0] Rx_DATA;
  logic                 Rx_VALID;
  logic                 Rx_PERROR;
  logic                 Rx_FERROR;
  logic                 Rx_BUSY;

  modport slave (
    input  baud_select, Rx_EN, RxD,
    output Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_BUSY
  );

  modport master (
    output baud_select, Rx_EN, RxD,
    input  Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_BUSY
  );
endinterface

// File: rtl/baud_controller.sv
// rtl/baud_controller.sv - 16x oversampling tick generator shared by UART TX and RX
// Purpose: free-running divider producing a one-clock sample_ENABLE pulse at 16x baud.
// Ports: clock, reset (async, active-high), baud_select[2:0] rate code, sample_ENABLE tick out.
module baud_controller
  import uart_pkg::*;
#(
  parameter int CLK_HZ = CLK_HZ_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] baud_select,
  output logic       sample_ENABLE
);

  logic [15:0] div_d;
  logic [15:0] count_q;
  logic        tick_q;

  always_comb div_d = baud_divisor(CLK_HZ, baud_select);

  // '>=' rather than '==' so a switch to a faster rate never has to wrap the counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else if (count_q >= div_d - 16'd1) begin
      count_q <= '0;
      tick_q  <= 1'b1;
    end else begin
      count_q <= count_q + 16'd1;
      tick_q  <= 1'b0;
    end
  end

  assign sample_ENABLE = tick_q;

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - UART receive path: 8 data bits, even parity, 1 stop, 16x oversampled
// Purpose: recovers bytes from RxD and reports parity/framing errors to host logic.
// Ports: clock, reset (async, active-high), bus (uart_receiver_if.slave):
//   baud_select, Rx_EN, RxD in; Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_BUSY out.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = CLK_HZ_DEFAULT,
  parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
  input  logic            clock,
  input  logic            reset,
  uart_receiver_if.slave  bus
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  rx_state_t            state_q;
  logic [2:0]           baud_sel_q;
  logic [1:0]           sync_q;
  logic                 rx_prev_q;
  logic [TICK_W-1:0]    tick_cnt_q;
  logic [BIT_W-1:0]     bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_err_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 perror_q;
  logic                 ferror_q;
  logic                 busy_q;
  logic                 sample_tick;
  logic                 rx_s;
  logic                 fall_d;

  // Rate is latched only while idle so a mid-frame change cannot disturb bit timing.
  baud_controller #(.CLK_HZ(CLK_HZ)) u_baud (
    .clock         (clock),
    .reset         (reset),
    .baud_select   (baud_sel_q),
    .sample_ENABLE (sample_tick)
  );

  // Two-flop synchronizer plus one history flop for start-edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[0], bus.RxD};
      rx_prev_q <= sync_q[1];
    end
  end

  assign rx_s   = sync_q[1];
  // Edge-, not level-triggered: a held break after a framing error never restarts.
  assign fall_d = rx_prev_q & ~rx_s;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      baud_sel_q <= '0;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_err_q  <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perror_q   <= 1'b0;
      ferror_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (state_q == IDLE) begin
        baud_sel_q <= bus.baud_select;
      end
      if (!bus.Rx_EN) begin
        // Abort: reported outputs keep their previous frame's values.
        state_q    <= IDLE;
        tick_cnt_q <= '0;
        bit_cnt_q  <= '0;
        busy_q     <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            if (fall_d) state_q <= START;
          end
          START: begin
            if (sample_tick) begin
              if (tick_cnt_q == TICK_MID) begin
                // Re-centre the tick count on mid-start so later samples land mid-bit.
                tick_cnt_q <= '0;
                if (!rx_s) begin
                  busy_q  <= 1'b1;
                  state_q <= DATA;
                end else begin
                  state_q <= IDLE;
                end
              end else begin
                tick_cnt_q <= tick_cnt_q + 1'b1;
              end
            end
          end
          DATA: begin
            if (sample_tick) begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
              if (tick_cnt_q == TICK_LAST) begin
                shift_q[bit_cnt_q] <= rx_s;
                if (bit_cnt_q == BIT_LAST) state_q <= PARITY;
                else bit_cnt_q <= bit_cnt_q + 1'b1;
              end
            end
          end
          PARITY: begin
            if (sample_tick) begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
              if (tick_cnt_q == TICK_LAST) begin
                par_err_q <= rx_s ^ (^shift_q);
                state_q   <= STOP;
              end
            end
          end
          STOP: begin
            if (sample_tick) begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
              if (tick_cnt_q == TICK_LAST) begin
                data_q   <= shift_q;
                perror_q <= par_err_q;
                ferror_q <= ~rx_s;
                valid_q  <= 1'b1;
                busy_q   <= 1'b0;
                state_q  <= IDLE;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.Rx_DATA   = data_q;
  assign bus.Rx_VALID  = valid_q;
  assign bus.Rx_PERROR = perror_q;
  assign bus.Rx_FERROR = ferror_q;
  assign bus.Rx_BUSY   = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - self-checking bench for uart_receiver
module tb_uart_receiver;

  localparam int TB_CLK_HZ = 3_686_400;

  logic clock = 1'b0;
  logic reset = 1'b1;

  uart_receiver_if bus ();

  uart_receiver #(.CLK_HZ(TB_CLK_HZ), .OVERSAMPLE(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] code;
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } rec_t;

  vec_t vt [8];
  rec_t got_q [$];
  rec_t exp_q [$];

  int total = 0;
  int bad = 0;
  int nvalid = 0;
  int valid_run = 0;
  int valid_wide = 0;
  int busy_run = 0;
  int last_busy = 0;
  int busy_rises = 0;
  logic busy_prev = 1'b0;

  int bc, nv0, br0;
  logic [2:0] rcode;
  logic [7:0] rdata;
  logic rbad, rstop, rpar;
  rec_t r;

  always @(negedge clock) begin
    if (bus.Rx_VALID === 1'b1) begin
      got_q.push_back('{bus.Rx_DATA, bus.Rx_PERROR, bus.Rx_FERROR});
      nvalid++;
      valid_run++;
      if (valid_run == 2) valid_wide++;
    end else begin
      valid_run = 0;
    end
    if (bus.Rx_BUSY === 1'b1) begin
      busy_run++;
      if (!busy_prev) busy_rises++;
    end else if (busy_run != 0) begin
      last_busy = busy_run;
      busy_run  = 0;
    end
    busy_prev = (bus.Rx_BUSY === 1'b1);
  end

  function automatic int bit_cycles(logic [2:0] code);
    int rate;
    case (code)
      3'd0: rate = 300;
      3'd1: rate = 1200;
      3'd2: rate = 4800;
      3'd3: rate = 9600;
      3'd4: rate = 19200;
      3'd5: rate = 38400;
      3'd6: rate = 57600;
      default: rate = 115200;
    endcase
    return 16 * ((TB_CLK_HZ + 8 * rate) / (16 * rate));
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_bit(logic b, int cyc);
    bus.RxD = b;
    tick(cyc);
  endtask

  task automatic send_frame(logic [7:0] d, logic p, logic s, int cyc);
    send_bit(1'b0, cyc);
    for (int i = 0; i < 8; i++) send_bit(d[i], cyc);
    send_bit(p, cyc);
    send_bit(s, cyc);
  endtask

  task automatic expect_frame(string tag, logic [7:0] d, logic pe, logic fe);
    rec_t g;
    check({tag, "_count"}, got_q.size(), 1);
    if (got_q.size() > 0) begin
      g = got_q.pop_front();
      check({tag, "_data"}, g.data, d);
      check({tag, "_perr"}, g.perr, pe);
      check({tag, "_ferr"}, g.ferr, fe);
    end
    got_q.delete();
  endtask

  task automatic set_rate(logic [2:0] code);
    bus.baud_select = code;
    bus.RxD = 1'b1;
    bc = bit_cycles(code);
    tick(2 * bc);
  endtask

  initial begin
    vt[0] = '{3'd7, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vt[1] = '{3'd7, 8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
    vt[2] = '{3'd6, 8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
    vt[3] = '{3'd5, 8'h07, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0};
    vt[4] = '{3'd7, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vt[5] = '{3'd7, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0};
    vt[6] = '{3'd4, 8'h80, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1};
    vt[7] = '{3'd6, 8'hC3, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1};

    bus.baud_select = 3'd7;
    bus.Rx_EN = 1'b1;
    bus.RxD = 1'b1;
    reset = 1'b1;
    tick(3);
    check("rst_data", bus.Rx_DATA, 8'h00);
    check("rst_valid", bus.Rx_VALID, 0);
    check("rst_perr", bus.Rx_PERROR, 0);
    check("rst_ferr", bus.Rx_FERROR, 0);
    check("rst_busy", bus.Rx_BUSY, 0);
    reset = 1'b0;
    tick(2);

    // 0xA5 at 115200 with busy window measurement.
    set_rate(3'd7);
    br0 = busy_rises;
    send_frame(8'hA5, 1'b0, 1'b1, bc);
    bus.RxD = 1'b1;
    tick(bc);
    expect_frame("a5", 8'hA5, 1'b0, 1'b0);
    check("a5_busy_rises", busy_rises - br0, 1);
    check("a5_busy_len_ok", int'(last_busy >= 10 * bc - bc / 2 && last_busy <= 11 * bc), 1);

    for (int i = 0; i < 8; i++) begin
      set_rate(vt[i].code);
      send_frame(vt[i].data, vt[i].par, vt[i].stop, bc);
      bus.RxD = 1'b1;
      tick(bc);
      expect_frame($sformatf("vec%0d", i), vt[i].exp_data, vt[i].exp_perr, vt[i].exp_ferr);
    end

    // Three-tick low glitch on an idle line.
    set_rate(3'd7);
    nv0 = nvalid;
    br0 = busy_rises;
    bus.RxD = 1'b0;
    tick(3 * bc / 16);
    bus.RxD = 1'b1;
    tick(2 * bc);
    check("glitch_valid", nvalid - nv0, 0);
    check("glitch_busy", busy_rises - br0, 0);

    // Back-to-back frames, no idle gap.
    got_q.delete();
    send_frame(8'h00, 1'b0, 1'b1, bc);
    send_frame(8'hFF, 1'b0, 1'b1, bc);
    bus.RxD = 1'b1;
    tick(bc);
    check("b2b_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("b2b_d0", got_q[0].data, 8'h00);
      check("b2b_d1", got_q[1].data, 8'hFF);
      check("b2b_err", {got_q[0].perr, got_q[0].ferr, got_q[1].perr, got_q[1].ferr}, 0);
    end
    got_q.delete();

    // Rx_EN dropped in data bit 4.
    set_rate(3'd7);
    nv0 = nvalid;
    fork
      send_frame(8'hA5, 1'b0, 1'b1, bc);
      begin
        tick(5 * bc + bc / 2);
        check("en_busy_before", bus.Rx_BUSY, 1);
        bus.Rx_EN = 1'b0;
        tick(1);
        check("en_busy_after", bus.Rx_BUSY, 0);
      end
    join
    bus.RxD = 1'b1;
    tick(bc);
    check("en_no_valid", nvalid - nv0, 0);
    check("en_data_hold", bus.Rx_DATA, 8'hFF);
    bus.Rx_EN = 1'b1;
    set_rate(3'd7);
    send_frame(8'h5A, 1'b0, 1'b1, bc);
    bus.RxD = 1'b1;
    tick(bc);
    expect_frame("en_next", 8'h5A, 1'b0, 1'b0);

    // Reset asserted in data bit 4, held to the end of the frame.
    nv0 = nvalid;
    fork
      send_frame(8'hA5, 1'b1, 1'b1, bc);
      begin
        tick(5 * bc + bc / 2);
        check("rst_busy_before", bus.Rx_BUSY, 1);
        reset = 1'b1;
        tick(1);
        check("rst_busy_after", bus.Rx_BUSY, 0);
      end
    join
    tick(2);
    reset = 1'b0;
    check("rst_no_valid", nvalid - nv0, 0);
    check("rst_data_clr", bus.Rx_DATA, 8'h00);
    set_rate(3'd7);
    send_frame(8'h5A, 1'b0, 1'b1, bc);
    bus.RxD = 1'b1;
    tick(bc);
    expect_frame("rst_next", 8'h5A, 1'b0, 1'b0);

    // 9600: framing error followed by a held break, then a clean frame.
    set_rate(3'd3);
    send_frame(8'h81, 1'b0, 1'b0, bc);
    nv0 = nvalid;
    br0 = busy_rises;
    tick(3 * bc);
    check("brk_no_valid", nvalid - nv0, 0);
    check("brk_no_busy", busy_rises - br0, 0);
    expect_frame("ferr", 8'h81, 1'b0, 1'b1);
    set_rate(3'd3);
    send_frame(8'h55, 1'b0, 1'b1, bc);
    bus.RxD = 1'b1;
    tick(bc);
    expect_frame("after_brk", 8'h55, 1'b0, 1'b0);

    // Randomized frames against the spec-level model.
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      rcode = 3'(5 + $urandom_range(0, 2));
      rdata = 8'($urandom);
      rbad  = ($urandom_range(0, 3) == 0);
      rstop = ($urandom_range(0, 4) != 0);
      rpar  = (^rdata) ^ rbad;
      exp_q.push_back('{rdata, rbad, ~rstop});
      set_rate(rcode);
      send_frame(rdata, rpar, rstop, bc);
      bus.RxD = 1'b1;
      tick(bc * int'($urandom_range(1, 2)));
    end
    check("rand_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("rand%0d_data", i), got_q[i].data, exp_q[i].data);
      check($sformatf("rand%0d_flags", i), {got_q[i].perr, got_q[i].ferr},
            {exp_q[i].perr, exp_q[i].ferr});
    end

    check("valid_one_cycle", valid_wide, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
